// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the sequential MAC neuron.
// FSM encodings plus sign-extend and saturating-add on a 64-bit carrier.
package neuron_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIRE = 2'd2;

  function automatic logic signed [63:0] sext(
    input logic [63:0] v,
    input int unsigned w
  );
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Clamp a+b to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Control/data bundle between the layer front-end and one neuron.
// Bias signals exist only when NEURON_MAC_BIAS_EN is defined.
interface neuron_mac_seq_if #(
  parameter int N_IN      = 32,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16
);
  localparam int ADDR_SIZE = $clog2(N_IN);

  logic [N_IN-1:0]      in;
  logic                 start;
  logic                 swr;
  logic [ADDR_SIZE-1:0] set_addr;
  logic [W_WIDTH-1:0]   set_weight;
  logic                 thr_wr;
  logic [ACC_WIDTH-1:0] set_thr;
`ifdef NEURON_MAC_BIAS_EN
  logic                 bias_wr;
  logic [ACC_WIDTH-1:0] set_bias;
`endif
  logic                 busy;
  logic                 done;
  logic                 out;
  logic [ACC_WIDTH-1:0] acc_out;

  modport master (
`ifdef NEURON_MAC_BIAS_EN
    output bias_wr, output set_bias,
`endif
    output in, output start,
    output swr, output set_addr,
    output set_weight,
    output thr_wr, output set_thr,
    input busy, input done,
    input out, input acc_out
  );

  modport slave (
`ifdef NEURON_MAC_BIAS_EN
    input bias_wr, input set_bias,
`endif
    input in, input start,
    input swr, input set_addr,
    input set_weight,
    input thr_wr, input set_thr,
    output busy, output done,
    output out, output acc_out
  );

endinterface

// File: rtl/neuron_weight_mem.sv
// N_IN x W_WIDTH weight register file.
// One gated sync write port, one combinational read port.
module neuron_weight_mem #(
  parameter int N_IN    = 32,
  parameter int W_WIDTH = 8,
  localparam int ADDR_SIZE = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [W_WIDTH-1:0]   wdata_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [W_WIDTH-1:0]   rdata_o
);

  logic [W_WIDTH-1:0] mem_q [N_IN];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < N_IN)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one saturating signed MAC per cycle.
// Optional NEURON_MAC_BIAS_EN preloads the accumulator with a bias.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_IN      = 32,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  localparam int ADDR_SIZE = $clog2(N_IN)
) (
  input logic            clk,
  input logic            rst_n,
  neuron_mac_seq_if.slave bus
);

  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic [N_IN-1:0] in_q, in_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] thr_q, thr_d;
  logic signed [ACC_WIDTH-1:0] thr_sh_q, thr_sh_d;
  logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic signed [ACC_WIDTH-1:0] acc_init;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic out_q, out_d;
  logic [W_WIDTH-1:0] w_rd;
  logic signed [63:0] term;
  logic accept;
  logic last;

`ifdef NEURON_MAC_BIAS_EN
  logic signed [ACC_WIDTH-1:0] bias_q, bias_d;

  always_comb begin
    bias_d = bias_q;
    if (bus.bias_wr) bias_d = bus.set_bias;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else        bias_q <= bias_d;
  end

  assign acc_init = bias_q;
`else
  assign acc_init = '0;
`endif

  neuron_weight_mem #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH)
  ) u_wmem (
    .clk     (clk),
    .we_i    (bus.swr & ~busy_q),
    .waddr_i (bus.set_addr),
    .wdata_i (bus.set_weight),
    .raddr_i (idx_q),
    .rdata_o (w_rd)
  );

  // busy_q also covers the done cycle, so a start there is ignored.
  assign accept = bus.start && (state_q == ST_IDLE) && !busy_q;
  assign last   = (idx_q == ADDR_SIZE'(N_IN - 1));
  assign term   = in_q[idx_q] ? sext(64'(w_rd), W_WIDTH) : '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_d      = in_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    thr_sh_d  = thr_sh_q;
    acc_out_d = acc_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    out_d     = out_q;
    if (bus.thr_wr) thr_d = bus.set_thr;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (accept) begin
          state_d  = ST_RUN;
          in_d     = bus.in;
          acc_d    = acc_init;
          idx_d    = '0;
          thr_sh_d = thr_q;
          busy_d   = 1'b1;
        end else if (done_q) begin
          busy_d = 1'b0;
        end
      end
      (state_q == ST_RUN): begin
        acc_d = ACC_WIDTH'(sat_add(
          sext(64'(acc_q), ACC_WIDTH),
          term, ACC_WIDTH));
        idx_d = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          state_d = ST_FIRE;
        end
      end
      (state_q == ST_FIRE): begin
        out_d     = (acc_q > thr_sh_q);
        acc_out_d = acc_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      in_q      <= '0;
      acc_q     <= '0;
      thr_q     <= '0;
      thr_sh_q  <= '0;
      acc_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_q      <= in_d;
      acc_q     <= acc_d;
      thr_q     <= thr_d;
      thr_sh_q  <= thr_sh_d;
      acc_out_q <= acc_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.out     = out_q;
  assign bus.acc_out = acc_out_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench: 16-bit and 10-bit accumulator neurons side by side.
// Bias case runs only when NEURON_MAC_BIAS_EN is defined.
module tb_neuron_mac_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   c;
  int   nd;

  neuron_mac_seq_if #(.N_IN(32), .W_WIDTH(8), .ACC_WIDTH(16)) a ();
  neuron_mac_seq_if #(.N_IN(32), .W_WIDTH(8), .ACC_WIDTH(10)) b ();

  neuron_mac_seq #(.N_IN(32), .W_WIDTH(8), .ACC_WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  neuron_mac_seq #(.N_IN(32), .W_WIDTH(8), .ACC_WIDTH(10)) u_dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_a(input int addr, input logic [7:0] v);
    @(negedge clk);
    a.swr = 1'b1;
    a.set_addr = 5'(addr);
    a.set_weight = v;
    @(negedge clk);
    a.swr = 1'b0;
  endtask

  task automatic thr_a(input logic [15:0] v);
    @(negedge clk);
    a.thr_wr = 1'b1;
    a.set_thr = v;
    @(negedge clk);
    a.thr_wr = 1'b0;
  endtask

  task automatic go_a(input logic [31:0] v);
    @(negedge clk);
    a.in = v;
    a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
  endtask

  task automatic wait_a(output int cyc);
    cyc = 0;
    while (!a.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!a.done) chk("timeout_a", a.done, 1);
  endtask

  task automatic wr_b(input int addr, input logic [7:0] v);
    @(negedge clk);
    b.swr = 1'b1;
    b.set_addr = 5'(addr);
    b.set_weight = v;
    @(negedge clk);
    b.swr = 1'b0;
  endtask

  task automatic go_b(input logic [31:0] v);
    @(negedge clk);
    b.in = v;
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (!b.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!b.done) chk("timeout_b", b.done, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    a.in = '0; a.start = 0; a.swr = 0; a.set_addr = '0;
    a.set_weight = '0; a.thr_wr = 0; a.set_thr = '0;
    b.in = '0; b.start = 0; b.swr = 0; b.set_addr = '0;
    b.set_weight = '0; b.thr_wr = 0; b.set_thr = '0;
`ifdef NEURON_MAC_BIAS_EN
    a.bias_wr = 0; a.set_bias = '0;
    b.bias_wr = 0; b.set_bias = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_out", a.out, 0);
    chk("rst_acc", a.acc_out, 0);
    chk("rst_acc10", b.acc_out, 0);

    for (int i = 0; i < 32; i++) wr_a(i, 8'd1);
    thr_a(16'd15);
    go_a(32'h0000FFFF);
    chk("busy_run", a.busy, 1);
    wait_a(c);
    chk("latency", c, 33);
    chk("sum16_acc", a.acc_out, 16'd16);
    chk("sum16_out", a.out, 1);
    @(negedge clk);
    chk("done_pulse", a.done, 0);
    chk("busy_clr", a.busy, 0);
    chk("acc_held", a.acc_out, 16'd16);

    thr_a(16'd16);
    go_a(32'h0000FFFF);
    wait_a(c);
    chk("thr_eq_acc", a.acc_out, 16'd16);
    chk("thr_eq_out", a.out, 0);

    wr_a(0, 8'h80);
    for (int i = 1; i < 32; i++) wr_a(i, 8'd0);
    thr_a(16'd0);
    go_a(32'h1);
    wait_a(c);
    chk("neg_acc", a.acc_out, 16'hFF80);
    chk("neg_out", a.out, 0);

    for (int i = 0; i < 32; i++) wr_b(i, 8'd127);
    go_b(32'hFFFFFFFF);
    wait_b(c);
    chk("satp_acc", b.acc_out, 10'h1FF);
    chk("satp_out", b.out, 1);
    for (int i = 0; i < 32; i++) wr_b(i, 8'h80);
    go_b(32'hFFFFFFFF);
    wait_b(c);
    chk("satn_acc", b.acc_out, 10'h200);
    chk("satn_out", b.out, 0);
    for (int i = 0; i < 32; i++) wr_b(i, (i < 8) ? 8'd127 : 8'hFF);
    go_b(32'hFFFFFFFF);
    wait_b(c);
    chk("offrail_acc", b.acc_out, 10'h1E7);
    chk("offrail_out", b.out, 1);

    wr_a(3, 8'd1);
    go_a(32'h8);
    repeat (2) @(negedge clk);
    a.swr = 1'b1; a.set_addr = 5'd3; a.set_weight = 8'd50;
    a.thr_wr = 1'b1; a.set_thr = 16'd100;
    @(negedge clk);
    a.swr = 1'b0; a.thr_wr = 1'b0;
    wait_a(c);
    chk("busywr_acc", a.acc_out, 16'd1);
    chk("thr_shadow", a.out, 1);
    go_a(32'h8);
    wait_a(c);
    chk("wr_dropped", a.acc_out, 16'd1);
    chk("thr_next", a.out, 0);
    thr_a(16'd0);
    @(negedge clk);
    a.swr = 1'b1; a.set_addr = 5'd3; a.set_weight = 8'd50;
    a.in = 32'h8; a.start = 1'b1;
    @(negedge clk);
    a.swr = 1'b0; a.start = 1'b0;
    wait_a(c);
    chk("wr_start_acc", a.acc_out, 16'd50);
    chk("wr_start_out", a.out, 1);

    go_a(32'h8);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      a.start = (i == 3 || i == 8 || i == 20);
      if (a.done) nd++;
    end
    a.start = 1'b0;
    chk("one_done", nd, 1);

    go_a(32'h8);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", a.busy, 0);
    chk("mrst_done", a.done, 0);
    chk("mrst_out", a.out, 0);
    chk("mrst_acc", a.acc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (a.done) nd++;
    end
    chk("mrst_nodone", nd, 0);
    chk("mrst_idle", a.busy, 0);

`ifdef NEURON_MAC_BIAS_EN
    for (int i = 0; i < 3; i++) wr_a(i, 8'd1);
    @(negedge clk);
    a.bias_wr = 1'b1; a.set_bias = 16'hFFFB;
    @(negedge clk);
    a.bias_wr = 1'b0;
    go_a(32'h7);
    wait_a(c);
    chk("bias_acc", a.acc_out, 16'hFFFE);
    chk("bias_out", a.out, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
